// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states and instruction constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } ifu_state_t;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam int unsigned ILEN_BYTES = 4;

  function automatic logic is_misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_skid.sv
// One-entry {pc, inst} holding buffer for a word that returns while decode is stalled.
module ifu_skid #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            clr,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_inst,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] inst
);

  // A simultaneous push and pop replaces the entry and keeps it valid.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clr) begin
      pc   <= push_pc;
      inst <= push_inst;
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues single-outstanding IRAM reads,
// and presents IR/PC to decode with a one-entry skid for stalls.
module ifu #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(cpu_pkg::NOP_INST)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            stall_i,
  input  logic            pc_wr_en_i,
  input  logic [XLEN-1:0] pc_wr_data_i,
  output logic            iram_rd_req_o,
  output logic [XLEN-1:0] iram_rd_addr_o,
  input  logic            iram_rd_ack_i,
  input  logic [XLEN-1:0] iram_rd_data_i,
  output logic [XLEN-1:0] ir_rd_data_o,
  output logic            ir_valid_o,
  output logic [XLEN-1:0] pc_rd_data_o,
  output logic            misaligned_o
);

  import cpu_pkg::*;

  ifu_state_t      state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] drain_addr;
  logic [XLEN-1:0] ir;
  logic [XLEN-1:0] pc_rd;
  logic            ir_valid;
  logic            pend;
  logic            mis;

  logic            skid_valid;
  logic            skid_push;
  logic            skid_pop;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_inst;

  logic            ack;
  logic            consume;
  logic            data_ok;

  // A pending request stays up even if the skid fills behind it.
  always_comb begin
    iram_rd_req_o = 1'b0;
    case (state)
      S_RUN:   iram_rd_req_o = !skid_valid || pend;
      S_DRAIN: iram_rd_req_o = 1'b1;
      default: iram_rd_req_o = 1'b0;
    endcase
  end

  assign iram_rd_addr_o = (state == S_DRAIN) ? drain_addr : fetch_pc;

  assign ack     = iram_rd_req_o && iram_rd_ack_i;
  assign consume = ir_valid && !stall_i && !pc_wr_en_i;
  assign data_ok = ack && (state == S_RUN) && !pc_wr_en_i;

  // Returned word lands in the skid when IR stays occupied after this edge.
  assign skid_pop  = consume && skid_valid;
  assign skid_push = data_ok && ir_valid && (!consume || skid_valid);

  ifu_skid #(.XLEN(XLEN)) u_skid (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr       (pc_wr_en_i),
    .push      (skid_push),
    .pop       (skid_pop),
    .push_pc   (fetch_pc),
    .push_inst (iram_rd_data_i),
    .valid     (skid_valid),
    .pc        (skid_pc),
    .inst      (skid_inst)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= S_BOOT;
      fetch_pc <= RESET_PC;
      pend     <= 1'b0;
      mis      <= 1'b0;
    end else begin
      mis  <= pc_wr_en_i && is_misaligned(pc_wr_data_i[1:0]);
      pend <= iram_rd_req_o && !iram_rd_ack_i;
      case (state)
        S_BOOT:  state <= S_RUN;
        S_RUN:   if (pc_wr_en_i && iram_rd_req_o && !iram_rd_ack_i) state <= S_DRAIN;
        S_DRAIN: if (iram_rd_ack_i) state <= S_RUN;
        default: state <= S_BOOT;
      endcase
      if (pc_wr_en_i) begin
        fetch_pc <= {pc_wr_data_i[XLEN-1:2], 2'b00};
      end else if (data_ok) begin
        fetch_pc <= fetch_pc + XLEN'(ILEN_BYTES);
      end
    end
  end

  // The abandoned request must keep its original address until acked.
  always_ff @(posedge clk_i) begin
    if (state == S_RUN && pc_wr_en_i && iram_rd_req_o && !iram_rd_ack_i) begin
      drain_addr <= fetch_pc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ir       <= NOP_INST;
      ir_valid <= 1'b0;
      pc_rd    <= RESET_PC;
    end else if (pc_wr_en_i) begin
      ir       <= NOP_INST;
      ir_valid <= 1'b0;
    end else if (consume) begin
      if (skid_valid) begin
        ir    <= skid_inst;
        pc_rd <= skid_pc;
      end else if (data_ok) begin
        ir    <= iram_rd_data_i;
        pc_rd <= fetch_pc;
      end else begin
        ir       <= NOP_INST;
        ir_valid <= 1'b0;
      end
    end else if (data_ok && !ir_valid) begin
      ir       <= iram_rd_data_i;
      pc_rd    <= fetch_pc;
      ir_valid <= 1'b1;
    end
  end

  assign ir_rd_data_o = ir;
  assign ir_valid_o   = ir_valid;
  assign pc_rd_data_o = pc_rd;
  assign misaligned_o = mis;

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
Instruction fetch unit, directly upstream of the instruction decoder. Owns the program counter and issues single-outstanding word reads to instruction RAM over a req/ack handshake. Presents the fetched instruction register (IR) and its PC to the decode stage, and accepts redirects (jump/branch/trap) from execute. A one-entry skid buffer absorbs a returning word while decode is stalled.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INST, 32'h0000_0013, IR value when empty/reset (addi x0,x0,0)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
stall_i  in  1  decode not ready; IR is consumed at an edge where ir_valid_o=1 and stall_i=0
pc_wr_en_i  in  1  redirect request from execute
pc_wr_data_i  in  XLEN  redirect target
iram_rd_req_o  out  1  read request
iram_rd_addr_o  out  XLEN  read word address
iram_rd_ack_i  in  1  read complete; only meaningful while req high
iram_rd_data_i  in  XLEN  read data, valid with ack
ir_rd_data_o  out  XLEN  instruction to decoder
ir_valid_o  out  1  IR holds a live instruction
pc_rd_data_o  out  XLEN  PC of the instruction in IR
misaligned_o  out  1  one-cycle pulse: redirect target had bits[1:0]!=0

Behaviour:
- Reset (async): fetch_pc=RESET_PC; ir=NOP_INST; ir_valid=0; pc_rd_data=RESET_PC; skid empty; req=0; misaligned=0; state=S_BOOT.
- FSM: S_BOOT (one cycle, no req) -> S_RUN. S_RUN: normal fetch. S_DRAIN: a redirect occurred with an unacked request; keep that request alive and discard its data.
- Handshake: once req is high, req and addr stay stable until the cycle ack=1. Zero-wait memory (ack in the request cycle) is legal and gives 1 instruction/cycle.
- S_RUN: req = !skid_valid, or a request already pending. addr = fetch_pc. On ack, fetch_pc <= fetch_pc+4 (mod 2^XLEN).
- Data routing on a consume edge: IR loads skid if skid valid, else ack data if ack, else ir_valid<=0 (IR reverts to NOP_INST).
- Data routing with no consume: ack data goes to IR if IR is empty, else to skid. Skid full forces req low next cycle.
- Order is strictly preserved: skid content always precedes newer ack data. No loss, no duplication.
- Redirect (pc_wr_en_i=1) takes priority over every other event that edge:
  - IR and skid are invalidated; fetch_pc <= {pc_wr_data_i[XLEN-1:2],2'b00}.
  - misaligned_o=1 next cycle iff pc_wr_data_i[1:0]!=0.
  - If req is high and ack=0: latch the old addr in drain_addr and go to S_DRAIN. addr = drain_addr while draining.
  - If ack=1 in the same cycle: data is dropped and the FSM stays in S_RUN; the next req uses the target.
- S_DRAIN: on ack, drop the data and go to S_RUN; the request to fetch_pc starts the following cycle. A further redirect in S_DRAIN updates fetch_pc and stays in S_DRAIN.
- Redirect plus simultaneous consume: the consume is ignored.
- pc_rd_data_o tracks the PC of the IR contents. The skid stores {pc, inst}.
- Latency: zero-wait memory gives first ir_valid 2 edges after reset release (S_BOOT, then req+ack).

Decomposition:
- cpu_pkg: ifu_state_t enum (S_BOOT, S_RUN, S_DRAIN); NOP_INST constant; ILEN_BYTES=4.
- Sub-module ifu_skid: one-entry {pc,inst} buffer with push/pop/valid. The FSM, PC and IR stay in ifu.

Test Plan:
1. Reset release, zero-wait memory (mem[a]=a|0x13), stall_i=0 -> addr 0,4,8… on consecutive cycles; IR/pc pairs (0x13,0),(0x17,4),(0x1B,8); ir_valid high from the 2nd edge.
2. Zero-wait memory, stall_i=1 for 3 cycles while IR holds pc 0x8 -> IR frozen; skid takes 0xC; req low during the stall; on release IR shows 0xC then 0x10; no gaps or duplicates.
3. Memory ack 3 cycles late; redirect to 0x100 one cycle after req of 0x20 -> addr stays 0x20 until ack; that data never appears on IR; next req addr 0x100; ir_valid low until it returns.
4. Redirect to 0x102 with ack in the same cycle -> misaligned_o pulses once; returned data dropped; next fetch addr 0x100; IR pc 0x100.
5. rst_n_i asserted mid-wait with req high -> outputs go immediately to reset values (req 0, IR 0x13, ir_valid 0); after release fetching restarts at RESET_PC.
6. RESET_PC=0xFFFF_FFFC, zero-wait memory -> fetch addrs 0xFFFF_FFFC then 0x0000_0000; pc_rd_data_o follows the same wrap.
